top: RTL and testbench
======================

TOP -- requirements
Module: top

Interface
REQ-001 Parameter LED_ADDR, default 32'h0000_0100, byte address of the memory-mapped LED register.
REQ-002 Parameter ROM_WORDS, default 64, instruction ROM depth in 32-bit words.
REQ-003 CLOCK_50  input  1   sole clock; all state updates on its rising edge.
REQ-004 KEY  input  4   KEY[0] SHALL be reset: synchronous, active-high; KEY[3:1] unused and ignored.
REQ-005 LEDR  output  10  registered LED register contents.

Function
REQ-006 The block SHALL contain a single-cycle RV32I-subset processor: one instruction fetched, executed and retired per clock.
REQ-007 Supported instructions: ADDI, ADD, SUB, SLLI, LUI, BEQ, BNE, JAL, LW, SW; any other encoding SHALL execute as a NOP (PC+4, no state change).
REQ-008 The PC is 32 bits; the ROM is indexed by PC[7:2] (wraps modulo ROM_WORDS); words beyond the program read as 0 (NOP).
REQ-009 The register file SHALL hold 32 x 32-bit registers; x0 reads 0, and writes to it are discarded.
REQ-010 Arithmetic SHALL be 32-bit modulo 2^32; immediates sign-extended per RV32I; branch/JAL offsets PC-relative; JAL writes PC+4 to rd.
REQ-011 SW to LED_ADDR SHALL load LEDR <= rs2[9:0] on that edge; SW elsewhere writes a 16-word data RAM indexed by addr[5:2].
REQ-012 LW from LED_ADDR SHALL return {22'b0, LEDR}; LW elsewhere reads the data RAM (combinational read).
REQ-013 The fixed ROM program SHALL be, in order from address 0: addi x1,x0,1; addi x2,x0,6; addi x3,x0,0x100; add x1,x1,x1; addi x2,x2,-1; bne x2,x0,-8; sw x1,0(x3); jal x0,0.
REQ-014 With this program, LEDR SHALL first become 10'b0001000000 on the 22nd rising edge after reset deasserts, and stay 0 before that.
REQ-015 After the SW, the processor SHALL spin on the self-loop JAL indefinitely, with LEDR held constant.

Reset
REQ-016 While KEY[0]=1 at a rising edge: PC<=0, all registers <=0, data RAM <=0, LEDR<=0.
REQ-017 Reset asserted mid-program SHALL abort the program on that edge; the program restarts from PC 0 on the first edge with KEY[0]=0.
REQ-018 A single-cycle reset pulse SHALL be sufficient.

Structure
REQ-019 Package top_pkg SHALL hold the opcode/funct constants, LED_ADDR default, ROM_WORDS default and the ROM program image.
REQ-020 The processor SHALL be the sub-module rv_core (fetch, decode, regfile, ALU, memory/LED port); top SHALL only map the board pins to it.

Verification
REQ-021 KEY=4'hF for 1 cycle, then 4'h0; run 100 cycles -> LEDR == 10'b0001000000.
REQ-022 Count edges after reset release -> LEDR == 0 through edge 21, == 10'd64 at edge 22, unchanged through edge 100.
REQ-023 Reset held high for 5 cycles -> LEDR == 0 and PC == 0 throughout.
REQ-024 KEY[0] pulsed at edge 10 and again at edge 30 -> LEDR returns to 0 immediately, then reaches 64 exactly 22 edges after each release.
REQ-025 Toggle KEY[3:1] randomly during the run -> no effect; LEDR == 64 from edge 22.
REQ-026 Inspect the register file after halt -> x1 == 64, x2 == 0, x3 == 0x100.

Source files
------------

// File: rtl/top_pkg.sv
// Shared constants for the board-level RV32I subset: opcodes, function codes,
// default memory map and the fixed program image.
package top_pkg;

    localparam logic [31:0] LED_ADDR_DEF  = 32'h0000_0100;
    localparam int          ROM_WORDS_DEF = 64;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_WORD    = 3'b010;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    // Doubles x1 six times, stores it to the LED register, then parks on a self-loop.
    function automatic logic [31:0] rom_word(input logic [5:0] idx);
        case (idx)
            6'd0:    return 32'h0010_0093; // addi x1, x0, 1
            6'd1:    return 32'h0060_0113; // addi x2, x0, 6
            6'd2:    return 32'h1000_0193; // addi x3, x0, 0x100
            6'd3:    return 32'h0010_80B3; // add  x1, x1, x1
            6'd4:    return 32'hFFF1_0113; // addi x2, x2, -1
            6'd5:    return 32'hFE01_1CE3; // bne  x2, x0, -8
            6'd6:    return 32'h0011_A023; // sw   x1, 0(x3)
            6'd7:    return 32'h0000_006F; // jal  x0, 0
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/top_if.sv
// Board-facing pin bundle between the pin map and the processor core.
interface top_if;
    logic       rst;
    logic [9:0] ledr;

    modport master (output rst, input ledr);
    modport slave  (input rst, output ledr);
endinterface

// File: rtl/rv_core.sv
// Single-cycle RV32I-subset core: ROM fetch, decode, 32x32 regfile, ALU,
// 16-word data RAM and a memory-mapped 10-bit LED register.
module rv_core
    import top_pkg::*;
#(
    parameter logic [31:0] LED_ADDR  = LED_ADDR_DEF,
    parameter int          ROM_WORDS = ROM_WORDS_DEF
) (
    input logic  clk,
    top_if.slave pins
);

    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] instr;
    logic [5:0]  rom_idx;
    logic [31:0] regs [32];
    logic [31:0] dmem [16];
    logic [9:0]  ledr_q;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] mem_addr;
    logic        is_led;
    logic [31:0] load_val;

    logic        rd_we;
    logic [31:0] rd_val;
    logic        dmem_we;
    logic        led_we;

    assign rom_idx = 6'(32'(pc[7:2]) % ROM_WORDS);
    assign instr   = rom_word(rom_idx);

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign f7     = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];

    assign mem_addr = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
    assign is_led   = (mem_addr == LED_ADDR);
    assign load_val = is_led ? {22'b0, ledr_q} : dmem[mem_addr[5:2]];

    // Unrecognised encodings fall through the defaults and behave as NOP.
    always_comb begin
        next_pc = pc + 32'd4;
        rd_we   = 1'b0;
        rd_val  = '0;
        dmem_we = 1'b0;
        led_we  = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                if (f3 == F3_ADD_SUB) begin
                    rd_we  = 1'b1;
                    rd_val = rs1_val + imm_i;
                end else if (f3 == F3_SLL && f7 == F7_BASE) begin
                    rd_we  = 1'b1;
                    rd_val = rs1_val << rs2;
                end
            end
            OPC_OP: begin
                if (f3 == F3_ADD_SUB && f7 == F7_BASE) begin
                    rd_we  = 1'b1;
                    rd_val = rs1_val + rs2_val;
                end else if (f3 == F3_ADD_SUB && f7 == F7_SUB) begin
                    rd_we  = 1'b1;
                    rd_val = rs1_val - rs2_val;
                end
            end
            OPC_LUI: begin
                rd_we  = 1'b1;
                rd_val = {instr[31:12], 12'b0};
            end
            OPC_BRANCH: begin
                if ((f3 == F3_BEQ && rs1_val == rs2_val) ||
                    (f3 == F3_BNE && rs1_val != rs2_val)) begin
                    next_pc = pc + imm_b;
                end
            end
            OPC_JAL: begin
                rd_we   = 1'b1;
                rd_val  = pc + 32'd4;
                next_pc = pc + imm_j;
            end
            OPC_LOAD: begin
                if (f3 == F3_WORD) begin
                    rd_we  = 1'b1;
                    rd_val = load_val;
                end
            end
            OPC_STORE: begin
                if (f3 == F3_WORD) begin
                    led_we  = is_led;
                    dmem_we = !is_led;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (pins.rst) begin
            pc     <= '0;
            ledr_q <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
            for (int j = 0; j < 16; j++) dmem[j] <= '0;
        end else begin
            pc <= next_pc;
            if (rd_we && rd != 5'd0) regs[rd] <= rd_val;
            if (dmem_we) dmem[mem_addr[5:2]] <= rs2_val;
            if (led_we) ledr_q <= rs2_val[9:0];
        end
    end

    assign pins.ledr = ledr_q;

endmodule

// File: rtl/top.sv
// Board pin map: KEY[0] is the synchronous reset, LEDR shows the core's LED register.
module top
    import top_pkg::*;
#(
    parameter logic [31:0] LED_ADDR  = LED_ADDR_DEF,
    parameter int          ROM_WORDS = ROM_WORDS_DEF
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    output logic [9:0] LEDR
);

    top_if u_pins ();

    logic unused_keys;

    assign u_pins.rst  = KEY[0];
    assign LEDR        = u_pins.ledr;
    assign unused_keys = ^KEY[3:1];

    rv_core #(
        .LED_ADDR  (LED_ADDR),
        .ROM_WORDS (ROM_WORDS)
    ) u_core (
        .clk  (CLOCK_50),
        .pins (u_pins.slave)
    );

endmodule

// File: tb/tb_top.sv
// Bench for top: random KEY[3:1] noise and reset pulses against a program-level model.
module tb_top;

    localparam int          LOOP_ITERS = 6;
    localparam int          HALT_EDGE  = 3 + 3 * LOOP_ITERS + 1;
    localparam logic [31:0] LED_FINAL  = 32'd1 << LOOP_ITERS;
    localparam logic [31:0] HALT_PC    = 32'd4 * 7;

    logic       clk;
    logic [2:0] key_hi;
    int         n_tests;
    int         n_fail;
    int         since;

    top_if bus ();

    top dut (
        .CLOCK_50 (clk),
        .KEY      ({key_hi, bus.rst}),
        .LEDR     (bus.ledr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (since=%0d)", tag, got, want, since);
        end
    endtask

    // Model: the program completes its store HALT_EDGE edges after reset release.
    function automatic logic [31:0] exp_led(input int n);
        return (n >= HALT_EDGE) ? LED_FINAL : 32'd0;
    endfunction

    task automatic step(input logic r);
        @(negedge clk);
        bus.rst = r;
        key_hi  = 3'($urandom_range(0, 7));
        @(posedge clk);
        #1;
        if (r) since = 0;
        else   since++;
        check_val("ledr", 32'(bus.ledr), exp_led(since));
        if (r) check_val("pc_in_reset", dut.u_core.pc, 32'd0);
        else if (since >= HALT_EDGE) check_val("pc_halt", dut.u_core.pc, HALT_PC);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        since   = 0;
        bus.rst = 1'b1;
        key_hi  = 3'b111;

        for (int i = 0; i < 5; i++) step(1'b1);

        for (int i = 0; i < 100; i++) step(1'b0);
        check_val("x1", dut.u_core.regs[1], LED_FINAL);
        check_val("x2", dut.u_core.regs[2], 32'd0);
        check_val("x3", dut.u_core.regs[3], 32'h100);
        check_val("x0", dut.u_core.regs[0], 32'd0);

        for (int n = 1; n <= 80; n++) step(n == 10 || n == 30);

        for (int run = 0; run < 4; run++) begin
            for (int n = 0; n < 60; n++) step($urandom_range(0, 24) == 0);
        end

        step(1'b1);
        for (int i = 0; i < 40; i++) step(1'b0);
        check_val("x1_end", dut.u_core.regs[1], LED_FINAL);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
